// File: rtl/router_pkg.sv
// Shared definitions for the router node: flit layout, two-phase token values,
// port/route encodings and the arbitration pick helper.
package router_pkg;

  localparam int FLIT_W    = 48;
  localparam int PAYLOAD_W = 40;
  localparam int COORD_W   = 4;
  localparam int DEST_Y_HI = 47;
  localparam int DEST_Y_LO = 44;
  localparam int DEST_X_HI = 43;
  localparam int DEST_X_LO = 40;
  localparam int NUM_PORTS = 3;

  localparam logic [1:0] DP_IDLE = 2'b10;
  localparam logic [1:0] DP_ALT  = 2'b01;

  typedef enum logic [1:0] {
    NORTH = 2'd0,
    EAST  = 2'd1,
    PE    = 2'd2
  } port_e;

  typedef enum logic [1:0] {
    ROUTE_SOUTH = 2'd0,
    ROUTE_WEST  = 2'd1,
    ROUTE_PE    = 2'd2
  } route_e;

  // Y-first dimension-order routing on the head flit.
  function automatic route_e compute_route(input logic [FLIT_W-1:0]  flit,
                                           input logic [COORD_W-1:0] x_local,
                                           input logic [COORD_W-1:0] y_local);
    route_e r;
    if (flit[DEST_Y_HI:DEST_Y_LO] != y_local)      r = ROUTE_SOUTH;
    else if (flit[DEST_X_HI:DEST_X_LO] != x_local) r = ROUTE_WEST;
    else                                           r = ROUTE_PE;
    return r;
  endfunction

  // One-hot grant of the first requester found scanning upward from start.
  function automatic logic [NUM_PORTS-1:0] arb_pick(input logic [NUM_PORTS-1:0] req,
                                                    input port_e                start);
    logic [NUM_PORTS-1:0] grant;
    int idx;
    grant = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if ((grant == '0) && req[idx]) grant[idx] = 1'b1;
    end
    return grant;
  endfunction

endpackage

// File: rtl/router_if.sv
// Link bundle for the router node: three input links and three output links.
interface router_if;
  import router_pkg::*;

  logic [FLIT_W-1:0]    north_channel_din;
  logic [1:0]           north_diff_pair_din;
  logic [FLIT_W-1:0]    east_channel_din;
  logic [1:0]           east_diff_pair_din;
  logic [FLIT_W-1:0]    pe_channel_din;
  logic [1:0]           pe_diff_pair_din;
  logic [FLIT_W-1:0]    south_channel_dout;
  logic [1:0]           south_diff_pair_dout;
  logic [FLIT_W-1:0]    west_channel_dout;
  logic [1:0]           west_diff_pair_dout;
  logic [PAYLOAD_W-1:0] pe_channel_dout;
  logic [1:0]           pe_diff_pair_dout;
  logic                 r2pe_ack_dout;

  modport slave (
    input  north_channel_din, north_diff_pair_din,
    input  east_channel_din, east_diff_pair_din,
    input  pe_channel_din, pe_diff_pair_din,
    output south_channel_dout, south_diff_pair_dout,
    output west_channel_dout, west_diff_pair_dout,
    output pe_channel_dout, pe_diff_pair_dout,
    output r2pe_ack_dout
  );

  modport master (
    output north_channel_din, north_diff_pair_din,
    output east_channel_din, east_diff_pair_din,
    output pe_channel_din, pe_diff_pair_din,
    input  south_channel_dout, south_diff_pair_dout,
    input  west_channel_dout, west_diff_pair_dout,
    input  pe_channel_dout, pe_diff_pair_dout,
    input  r2pe_ack_dout
  );

endinterface

// File: rtl/router_input_buffer.sv
// One router input: two-phase token decode, flit FIFO and head route compute.
module router_input_buffer
  import router_pkg::*;
#(
  parameter logic [COORD_W-1:0] X_LOCAL   = 4'd1,
  parameter logic [COORD_W-1:0] Y_LOCAL   = 4'd1,
  parameter int                 BUF_DEPTH = 4
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic [FLIT_W-1:0] channel_din,
  input  logic [1:0]        diff_pair_din,
  output logic [FLIT_W-1:0] flit_out,
  output route_e            route,
  output logic              valid,
  input  logic              pop,
  output logic              accepted
);

  localparam int PTR_W = $clog2(BUF_DEPTH);

  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic [1:0]        last_dp_q, last_dp_d;
  logic              accepted_q, accepted_d;
  logic [FLIT_W-1:0] mem_q [BUF_DEPTH];
  logic [FLIT_W-1:0] mem_d [BUF_DEPTH];

  logic new_flit, empty, full, do_pop, do_write;

  always_comb begin
    new_flit  = ((diff_pair_din == DP_IDLE) || (diff_pair_din == DP_ALT)) &&
                (diff_pair_din != last_dp_q);
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    do_pop    = pop && !empty;
    // A pop on the same edge frees the slot the incoming flit needs.
    do_write  = new_flit && (!full || do_pop);
    last_dp_d = new_flit ? diff_pair_din : last_dp_q;
    wr_ptr_d  = wr_ptr_q + {{PTR_W{1'b0}}, do_write};
    rd_ptr_d  = rd_ptr_q + {{PTR_W{1'b0}}, do_pop};
    accepted_d = do_write;
    mem_d = mem_q;
    if (do_write) mem_d[wr_ptr_q[PTR_W-1:0]] = channel_din;
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      last_dp_q  <= DP_IDLE;
      accepted_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      last_dp_q  <= last_dp_d;
      accepted_q <= accepted_d;
    end
  end

  always_ff @(posedge clka) begin
    mem_q <= mem_d;
  end

  assign flit_out = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign valid    = !empty;
  assign route    = compute_route(flit_out, X_LOCAL, Y_LOCAL);
  assign accepted = accepted_q;

endmodule

// File: rtl/router.sv
// 3-in/3-out mesh router node with per-output arbitration and registered outputs.
// Build option ROUTER_RR_ARB_EN: round-robin arbitration instead of fixed north > east > pe.
module router
  import router_pkg::*;
#(
  parameter logic [COORD_W-1:0] X_LOCAL   = 4'd1,
  parameter logic [COORD_W-1:0] Y_LOCAL   = 4'd1,
  parameter int                 BUF_DEPTH = 4
) (
  input logic      clka,
  input logic      rsta,
  router_if.slave  bus
);

  logic [FLIT_W-1:0]    head [NUM_PORTS];
  route_e               route [NUM_PORTS];
  logic [NUM_PORTS-1:0] valid;
  logic [NUM_PORTS-1:0] pop;
  logic [NUM_PORTS-1:0] accepted;
  logic                 unused_accepted;

  // Outer index is the output (ROUTE_*), inner bit is the input (NORTH/EAST/PE).
  logic [NUM_PORTS-1:0] req   [NUM_PORTS];
  logic [NUM_PORTS-1:0] grant [NUM_PORTS];
  logic [FLIT_W-1:0]    sel   [NUM_PORTS];

  logic [FLIT_W-1:0]    south_q, south_d;
  logic [FLIT_W-1:0]    west_q, west_d;
  logic [PAYLOAD_W-1:0] pe_q, pe_d;
  logic [1:0]           dp_q [NUM_PORTS];
  logic [1:0]           dp_d [NUM_PORTS];

  router_input_buffer #(.X_LOCAL(X_LOCAL), .Y_LOCAL(Y_LOCAL), .BUF_DEPTH(BUF_DEPTH)) u_north (
    .clka(clka), .rsta(rsta),
    .channel_din(bus.north_channel_din), .diff_pair_din(bus.north_diff_pair_din),
    .flit_out(head[0]), .route(route[0]), .valid(valid[0]),
    .pop(pop[0]), .accepted(accepted[0])
  );

  router_input_buffer #(.X_LOCAL(X_LOCAL), .Y_LOCAL(Y_LOCAL), .BUF_DEPTH(BUF_DEPTH)) u_east (
    .clka(clka), .rsta(rsta),
    .channel_din(bus.east_channel_din), .diff_pair_din(bus.east_diff_pair_din),
    .flit_out(head[1]), .route(route[1]), .valid(valid[1]),
    .pop(pop[1]), .accepted(accepted[1])
  );

  router_input_buffer #(.X_LOCAL(X_LOCAL), .Y_LOCAL(Y_LOCAL), .BUF_DEPTH(BUF_DEPTH)) u_pe (
    .clka(clka), .rsta(rsta),
    .channel_din(bus.pe_channel_din), .diff_pair_din(bus.pe_diff_pair_din),
    .flit_out(head[2]), .route(route[2]), .valid(valid[2]),
    .pop(pop[2]), .accepted(accepted[2])
  );

  assign unused_accepted = accepted[0] | accepted[1];

`ifdef ROUTER_RR_ARB_EN
  port_e ptr_q [NUM_PORTS];
  port_e ptr_d [NUM_PORTS];

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      ptr_d[o] = ptr_q[o];
      case (grant[o])
        3'b001:  ptr_d[o] = EAST;
        3'b010:  ptr_d[o] = PE;
        3'b100:  ptr_d[o] = NORTH;
        default: ptr_d[o] = ptr_q[o];
      endcase
    end
  end

  always_ff @(posedge clka) begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (rsta) ptr_q[o] <= NORTH;
      else      ptr_q[o] <= ptr_d[o];
    end
  end
`endif

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      req[o]   = '0;
      grant[o] = '0;
      sel[o]   = '0;
    end
    pop = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req[0][i] = valid[i] && (route[i] == ROUTE_SOUTH);
      req[1][i] = valid[i] && (route[i] == ROUTE_WEST);
      req[2][i] = valid[i] && (route[i] == ROUTE_PE);
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
`ifdef ROUTER_RR_ARB_EN
      grant[o] = arb_pick(req[o], ptr_q[o]);
`else
      grant[o] = arb_pick(req[o], NORTH);
`endif
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant[o][i]) sel[o] = head[i];
      end
      pop = pop | grant[o];
    end
  end

  always_comb begin
    south_d = south_q;
    west_d  = west_q;
    pe_d    = pe_q;
    for (int o = 0; o < NUM_PORTS; o++) begin
      dp_d[o] = dp_q[o];
      if (grant[o] != '0) dp_d[o] = ~dp_q[o];
    end
    if (grant[0] != '0) south_d = sel[0];
    if (grant[1] != '0) west_d  = sel[1];
    if (grant[2] != '0) pe_d    = sel[2][PAYLOAD_W-1:0];
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      south_q <= '0;
      west_q  <= '0;
      pe_q    <= '0;
      for (int o = 0; o < NUM_PORTS; o++) dp_q[o] <= DP_IDLE;
    end else begin
      south_q <= south_d;
      west_q  <= west_d;
      pe_q    <= pe_d;
      for (int o = 0; o < NUM_PORTS; o++) dp_q[o] <= dp_d[o];
    end
  end

  assign bus.south_channel_dout   = south_q;
  assign bus.south_diff_pair_dout = dp_q[0];
  assign bus.west_channel_dout    = west_q;
  assign bus.west_diff_pair_dout  = dp_q[1];
  assign bus.pe_channel_dout      = pe_q;
  assign bus.pe_diff_pair_dout    = dp_q[2];
  assign bus.r2pe_ack_dout        = accepted[2];

endmodule

// File: tb/tb_router.sv
// Directed self-checking bench for the router node at X_LOCAL = Y_LOCAL = 1.
module tb_router;
  import router_pkg::*;

  logic clka = 1'b0;
  logic rsta;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [1:0]  exp_sdp;
  logic [47:0] nflit;
  logic [47:0] pflit;

  router_if rif ();

  router #(.X_LOCAL(4'd1), .Y_LOCAL(4'd1), .BUF_DEPTH(4)) dut (
    .clka(clka),
    .rsta(rsta),
    .bus (rif.slave)
  );

  always #5 clka = ~clka;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clka);
    @(negedge clka);
  endtask

  function automatic logic [1:0] flip(input logic [1:0] dp);
    return (dp == DP_IDLE) ? DP_ALT : DP_IDLE;
  endfunction

  task automatic check_all(input string tag, input logic [47:0] s, input logic [1:0] sdp,
                           input logic [47:0] w, input logic [1:0] wdp,
                           input logic [39:0] p, input logic [1:0] pdp);
    check({tag, "_south"},    rif.south_channel_dout, s);
    check({tag, "_south_dp"}, {46'd0, rif.south_diff_pair_dout}, {46'd0, sdp});
    check({tag, "_west"},     rif.west_channel_dout, w);
    check({tag, "_west_dp"},  {46'd0, rif.west_diff_pair_dout}, {46'd0, wdp});
    check({tag, "_pe"},       {8'd0, rif.pe_channel_dout}, {8'd0, p});
    check({tag, "_pe_dp"},    {46'd0, rif.pe_diff_pair_dout}, {46'd0, pdp});
  endtask

  task automatic check_ack(input string tag, input logic exp);
    check(tag, {47'd0, rif.r2pe_ack_dout}, {47'd0, exp});
  endtask

  initial begin
    rsta = 1'b1;
    rif.north_channel_din   = '0;
    rif.north_diff_pair_din = DP_IDLE;
    rif.east_channel_din    = '0;
    rif.east_diff_pair_din  = DP_IDLE;
    rif.pe_channel_din      = '0;
    rif.pe_diff_pair_din    = DP_IDLE;
    repeat (20) @(posedge clka);
    @(negedge clka);
    rsta = 1'b0;

    // 1: reset state, then idle inputs cause no toggles
    check_all("rst", 48'h0, DP_IDLE, 48'h0, DP_IDLE, 40'h0, DP_IDLE);
    check_ack("rst_ack", 1'b0);
    repeat (3) tick();
    check_all("idle", 48'h0, DP_IDLE, 48'h0, DP_IDLE, 40'h0, DP_IDLE);

    // 2: north flit to south
    rif.north_channel_din   = 48'h210000000000;
    rif.north_diff_pair_din = DP_ALT;
    tick();
    check("n2s_not_yet_dp", {46'd0, rif.south_diff_pair_dout}, {46'd0, DP_IDLE});
    check_ack("n2s_ack", 1'b0);
    tick();
    check_all("n2s", 48'h210000000000, DP_ALT, 48'h0, DP_IDLE, 40'h0, DP_IDLE);

    // 3: east flit to west
    rif.east_channel_din   = 48'h121111111111;
    rif.east_diff_pair_din = DP_ALT;
    repeat (2) tick();
    check_all("e2w", 48'h210000000000, DP_ALT, 48'h121111111111, DP_ALT, 40'h0, DP_IDLE);

    // 4: PE-injected flit to south with ack pulse
    rif.pe_channel_din   = 48'h333333333333;
    rif.pe_diff_pair_din = DP_ALT;
    tick();
    check_ack("pe_ack_hi", 1'b1);
    check("pe2s_not_yet", rif.south_channel_dout, 48'h210000000000);
    tick();
    check_ack("pe_ack_lo", 1'b0);
    check_all("pe2s", 48'h333333333333, DP_IDLE, 48'h121111111111, DP_ALT, 40'h0, DP_IDLE);

    // 5: north and east contend for west on the same edge
    rif.north_channel_din   = 48'h120000000000;
    rif.north_diff_pair_din = DP_IDLE;
    rif.east_channel_din    = 48'h121111111111;
    rif.east_diff_pair_din  = DP_IDLE;
    repeat (2) tick();
    check("cont_first",    rif.west_channel_dout, 48'h120000000000);
    check("cont_first_dp", {46'd0, rif.west_diff_pair_dout}, {46'd0, DP_IDLE});
    tick();
    check("cont_second",    rif.west_channel_dout, 48'h121111111111);
    check("cont_second_dp", {46'd0, rif.west_diff_pair_dout}, {46'd0, DP_ALT});
    tick();
    check("cont_hold_dp", {46'd0, rif.west_diff_pair_dout}, {46'd0, DP_ALT});

    // 6a: flit for this node delivered to PE as payload only
    rif.north_channel_din   = 48'h11ABCDEF0123;
    rif.north_diff_pair_din = DP_ALT;
    repeat (2) tick();
    check_all("n2pe", 48'h333333333333, DP_IDLE, 48'h121111111111, DP_ALT, 40'hABCDEF0123, DP_ALT);
    check_ack("n2pe_ack", 1'b0);

    // 6b: illegal token 11 and an unchanged token are ignored
    rif.north_channel_din   = 48'h210000000000;
    rif.north_diff_pair_din = 2'b11;
    repeat (2) tick();
    check("tok11_south",    rif.south_channel_dout, 48'h333333333333);
    check("tok11_south_dp", {46'd0, rif.south_diff_pair_dout}, {46'd0, DP_IDLE});
    rif.north_diff_pair_din = DP_ALT;
    repeat (2) tick();
    check("tok_same_dp", {46'd0, rif.south_diff_pair_dout}, {46'd0, DP_IDLE});

    // 6c: north saturates south while PE injects 5 flits; the 5th finds a full FIFO
    exp_sdp = DP_IDLE;
    for (int k = 0; k < 5; k++) begin
      rif.north_channel_din   = 48'h200000000000 + 48'(k);
      rif.north_diff_pair_din = flip(rif.north_diff_pair_din);
      rif.pe_channel_din      = 48'h3000000000A0 + 48'(k);
      rif.pe_diff_pair_din    = flip(rif.pe_diff_pair_din);
      tick();
      check_ack($sformatf("sat_ack%0d", k), (k < 4) ? 1'b1 : 1'b0);
      if (k >= 1) begin
        exp_sdp = flip(exp_sdp);
        nflit = 48'h200000000000 + 48'(k - 1);
        check($sformatf("sat_n%0d", k - 1), rif.south_channel_dout, nflit);
        check($sformatf("sat_n%0d_dp", k - 1), {46'd0, rif.south_diff_pair_dout}, {46'd0, exp_sdp});
      end
    end
    tick();
    exp_sdp = flip(exp_sdp);
    check("sat_n4", rif.south_channel_dout, 48'h200000000004);
    check("sat_n4_dp", {46'd0, rif.south_diff_pair_dout}, {46'd0, exp_sdp});
    check_ack("sat_ack_after", 1'b0);
    for (int j = 0; j < 4; j++) begin
      tick();
      exp_sdp = flip(exp_sdp);
      pflit = 48'h3000000000A0 + 48'(j);
      check($sformatf("drain_p%0d", j), rif.south_channel_dout, pflit);
      check($sformatf("drain_p%0d_dp", j), {46'd0, rif.south_diff_pair_dout}, {46'd0, exp_sdp});
    end
    repeat (2) tick();
    check("drop_p4", rif.south_channel_dout, 48'h3000000000A3);
    check("drop_p4_dp", {46'd0, rif.south_diff_pair_dout}, {46'd0, exp_sdp});

    // Reset mid-operation: captured flit is lost
    rif.north_channel_din   = 48'h210000000055;
    rif.north_diff_pair_din = flip(rif.north_diff_pair_din);
    tick();
    rsta = 1'b1;
    rif.north_diff_pair_din = DP_IDLE;
    rif.east_diff_pair_din  = DP_IDLE;
    rif.pe_diff_pair_din    = DP_IDLE;
    tick();
    rsta = 1'b0;
    check_all("midrst", 48'h0, DP_IDLE, 48'h0, DP_IDLE, 40'h0, DP_IDLE);
    repeat (2) tick();
    check_all("midrst_lost", 48'h0, DP_IDLE, 48'h0, DP_IDLE, 40'h0, DP_IDLE);
    check_ack("midrst_ack", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
